// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcode encodings and beat-count helpers for the crossbar legs.
package tl_ul_pkg;

  typedef enum logic [2:0] {
    PutFull    = 3'd0,
    PutPartial = 3'd1,
    Arithmetic = 3'd2,
    Logical    = 3'd3,
    Get        = 3'd4,
    Intent     = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1,
    HintAck       = 3'd2
  } tl_d_op_e;

  function automatic logic has_data(input logic [2:0] opcode);
    case (tl_a_op_e'(opcode))
      PutFull, PutPartial, Arithmetic, Logical: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic int unsigned num_beats(input int unsigned size, input int unsigned beat_bytes);
    int unsigned bytes;
    bytes = 32'd1 << size;
    return (bytes > beat_bytes) ? bytes / beat_bytes : 32'd1;
  endfunction

endpackage

// File: rtl/tl_rr_lock_arb.sv
// Two-way round-robin grant with burst lock; grant is combinational, state is registered.
module tl_rr_lock_arb
  import tl_ul_pkg::*;
#(
  parameter int unsigned SIZE_W     = 3,
  parameter int unsigned BEAT_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [SIZE_W-1:0] a_size,
  output logic              grant,
  output logic              busy
);

  // Counter sized to hold the longest burst the size field can encode.
  localparam int unsigned CNT_W = 2 ** SIZE_W;

  logic             rr_ptr;
  logic             lock;
  logic             lock_id;
  logic [CNT_W-1:0] beats_left;
  logic             fire;
  int unsigned      beats;

  always_comb begin
    grant = 1'b0;
    if (lock)         grant = lock_id;
    else if (&req)    grant = rr_ptr;
    else if (req[1])  grant = 1'b1;
  end

  assign fire  = req[grant] & a_ready;
  assign beats = num_beats(32'(a_size), BEAT_BYTES);
  assign busy  = lock;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      lock       <= 1'b0;
      lock_id    <= 1'b0;
      beats_left <= '0;
    end else if (fire) begin
      if (!lock) begin
        rr_ptr <= ~grant;
        if (has_data(a_opcode) && beats > 32'd1) begin
          lock       <= 1'b1;
          lock_id    <= grant;
          beats_left <= CNT_W'(beats - 32'd1);
        end
      end else begin
        beats_left <= beats_left - CNT_W'(1);
        if (beats_left == CNT_W'(1)) lock <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tl_ul_a_arbiter_2to1.sv
// Two-client TL-UL A-channel merge with source tagging and tag-routed D responses.
module tl_ul_a_arbiter_2to1
  import tl_ul_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned SRC_W      = 1,
  parameter int unsigned SIZE_W     = 3,
  parameter int unsigned BEAT_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    c0_a_valid,
  output logic                    c0_a_ready,
  input  logic [2:0]              c0_a_opcode,
  input  logic [2:0]              c0_a_param,
  input  logic [SIZE_W-1:0]       c0_a_size,
  input  logic [SRC_W-1:0]        c0_a_source,
  input  logic [ADDR_W-1:0]       c0_a_address,
  input  logic [BEAT_BYTES-1:0]   c0_a_mask,
  input  logic [8*BEAT_BYTES-1:0] c0_a_data,
  input  logic                    c1_a_valid,
  output logic                    c1_a_ready,
  input  logic [2:0]              c1_a_opcode,
  input  logic [2:0]              c1_a_param,
  input  logic [SIZE_W-1:0]       c1_a_size,
  input  logic [SRC_W-1:0]        c1_a_source,
  input  logic [ADDR_W-1:0]       c1_a_address,
  input  logic [BEAT_BYTES-1:0]   c1_a_mask,
  input  logic [8*BEAT_BYTES-1:0] c1_a_data,
  output logic                    m_a_valid,
  input  logic                    m_a_ready,
  output logic [2:0]              m_a_opcode,
  output logic [2:0]              m_a_param,
  output logic [SIZE_W-1:0]       m_a_size,
  output logic [SRC_W:0]          m_a_source,
  output logic [ADDR_W-1:0]       m_a_address,
  output logic [BEAT_BYTES-1:0]   m_a_mask,
  output logic [8*BEAT_BYTES-1:0] m_a_data,
  input  logic                    m_d_valid,
  output logic                    m_d_ready,
  input  logic [2:0]              m_d_opcode,
  input  logic [1:0]              m_d_param,
  input  logic [SIZE_W-1:0]       m_d_size,
  input  logic [SRC_W:0]          m_d_source,
  input  logic                    m_d_sink,
  input  logic                    m_d_denied,
  input  logic                    m_d_corrupt,
  input  logic [8*BEAT_BYTES-1:0] m_d_data,
  output logic                    c0_d_valid,
  input  logic                    c0_d_ready,
  output logic [2:0]              c0_d_opcode,
  output logic [1:0]              c0_d_param,
  output logic [SIZE_W-1:0]       c0_d_size,
  output logic [SRC_W-1:0]        c0_d_source,
  output logic                    c0_d_sink,
  output logic                    c0_d_denied,
  output logic                    c0_d_corrupt,
  output logic [8*BEAT_BYTES-1:0] c0_d_data,
  output logic                    c1_d_valid,
  input  logic                    c1_d_ready,
  output logic [2:0]              c1_d_opcode,
  output logic [1:0]              c1_d_param,
  output logic [SIZE_W-1:0]       c1_d_size,
  output logic [SRC_W-1:0]        c1_d_source,
  output logic                    c1_d_sink,
  output logic                    c1_d_denied,
  output logic                    c1_d_corrupt,
  output logic [8*BEAT_BYTES-1:0] c1_d_data,
  output logic                    busy
);

  logic grant;
  logic dst;

  tl_rr_lock_arb #(
    .SIZE_W    (SIZE_W),
    .BEAT_BYTES(BEAT_BYTES)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({c1_a_valid, c0_a_valid}),
    .a_ready (m_a_ready),
    .a_opcode(m_a_opcode),
    .a_size  (m_a_size),
    .grant   (grant),
    .busy    (busy)
  );

  always_comb begin
    c0_a_ready = 1'b0;
    c1_a_ready = 1'b0;
    if (grant) begin
      m_a_valid   = c1_a_valid;
      c1_a_ready  = m_a_ready;
      m_a_opcode  = c1_a_opcode;
      m_a_param   = c1_a_param;
      m_a_size    = c1_a_size;
      m_a_source  = {1'b1, c1_a_source};
      m_a_address = c1_a_address;
      m_a_mask    = c1_a_mask;
      m_a_data    = c1_a_data;
    end else begin
      m_a_valid   = c0_a_valid;
      c0_a_ready  = m_a_ready;
      m_a_opcode  = c0_a_opcode;
      m_a_param   = c0_a_param;
      m_a_size    = c0_a_size;
      m_a_source  = {1'b0, c0_a_source};
      m_a_address = c0_a_address;
      m_a_mask    = c0_a_mask;
      m_a_data    = c0_a_data;
    end
  end

  assign dst        = m_d_source[SRC_W];
  assign c0_d_valid = m_d_valid & ~dst;
  assign c1_d_valid = m_d_valid &  dst;
  assign m_d_ready  = dst ? c1_d_ready : c0_d_ready;

  assign c0_d_opcode  = m_d_opcode;
  assign c0_d_param   = m_d_param;
  assign c0_d_size    = m_d_size;
  assign c0_d_source  = m_d_source[SRC_W-1:0];
  assign c0_d_sink    = m_d_sink;
  assign c0_d_denied  = m_d_denied;
  assign c0_d_corrupt = m_d_corrupt;
  assign c0_d_data    = m_d_data;
  assign c1_d_opcode  = m_d_opcode;
  assign c1_d_param   = m_d_param;
  assign c1_d_size    = m_d_size;
  assign c1_d_source  = m_d_source[SRC_W-1:0];
  assign c1_d_sink    = m_d_sink;
  assign c1_d_denied  = m_d_denied;
  assign c1_d_corrupt = m_d_corrupt;
  assign c1_d_data    = m_d_data;

endmodule

// File: tb/tb_tl_ul_a_arbiter_2to1.sv
// Directed plus random bench for the 2:1 TL-UL A arbiter against a transaction-level model.
module tb_tl_ul_a_arbiter_2to1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Stimulus state, indexed by client
  logic        t_v     [2];
  logic [2:0]  t_op    [2];
  logic [2:0]  t_par   [2];
  logic [2:0]  t_size  [2];
  logic        t_src   [2];
  logic [29:0] t_addr  [2];
  logic [3:0]  t_mask  [2];
  logic [31:0] t_data  [2];
  logic        t_dready[2];
  logic        t_mready;
  logic        t_dvalid;
  logic [1:0]  t_dsrc;
  logic [2:0]  t_dop;
  logic [1:0]  t_dpar;
  logic [2:0]  t_dsize;
  logic        t_dsink, t_ddenied, t_dcorrupt;
  logic [31:0] t_ddata;

  logic        c0_a_ready, c1_a_ready, m_a_valid, m_d_ready, busy;
  logic [2:0]  m_a_opcode, m_a_param, m_a_size;
  logic [1:0]  m_a_source;
  logic [29:0] m_a_address;
  logic [3:0]  m_a_mask;
  logic [31:0] m_a_data;
  logic        c0_d_valid, c1_d_valid;
  logic [2:0]  c0_d_opcode, c1_d_opcode, c0_d_size, c1_d_size;
  logic [1:0]  c0_d_param, c1_d_param;
  logic        c0_d_source, c1_d_source, c0_d_sink, c1_d_sink;
  logic        c0_d_denied, c1_d_denied, c0_d_corrupt, c1_d_corrupt;
  logic [31:0] c0_d_data, c1_d_data;

  tl_ul_a_arbiter_2to1 #(.ADDR_W(30), .SRC_W(1), .SIZE_W(3), .BEAT_BYTES(4)) dut (
    .clock(clock), .reset(reset),
    .c0_a_valid(t_v[0]), .c0_a_ready(c0_a_ready), .c0_a_opcode(t_op[0]), .c0_a_param(t_par[0]),
    .c0_a_size(t_size[0]), .c0_a_source(t_src[0]), .c0_a_address(t_addr[0]),
    .c0_a_mask(t_mask[0]), .c0_a_data(t_data[0]),
    .c1_a_valid(t_v[1]), .c1_a_ready(c1_a_ready), .c1_a_opcode(t_op[1]), .c1_a_param(t_par[1]),
    .c1_a_size(t_size[1]), .c1_a_source(t_src[1]), .c1_a_address(t_addr[1]),
    .c1_a_mask(t_mask[1]), .c1_a_data(t_data[1]),
    .m_a_valid(m_a_valid), .m_a_ready(t_mready), .m_a_opcode(m_a_opcode), .m_a_param(m_a_param),
    .m_a_size(m_a_size), .m_a_source(m_a_source), .m_a_address(m_a_address),
    .m_a_mask(m_a_mask), .m_a_data(m_a_data),
    .m_d_valid(t_dvalid), .m_d_ready(m_d_ready), .m_d_opcode(t_dop), .m_d_param(t_dpar),
    .m_d_size(t_dsize), .m_d_source(t_dsrc), .m_d_sink(t_dsink), .m_d_denied(t_ddenied),
    .m_d_corrupt(t_dcorrupt), .m_d_data(t_ddata),
    .c0_d_valid(c0_d_valid), .c0_d_ready(t_dready[0]), .c0_d_opcode(c0_d_opcode),
    .c0_d_param(c0_d_param), .c0_d_size(c0_d_size), .c0_d_source(c0_d_source),
    .c0_d_sink(c0_d_sink), .c0_d_denied(c0_d_denied), .c0_d_corrupt(c0_d_corrupt),
    .c0_d_data(c0_d_data),
    .c1_d_valid(c1_d_valid), .c1_d_ready(t_dready[1]), .c1_d_opcode(c1_d_opcode),
    .c1_d_param(c1_d_param), .c1_d_size(c1_d_size), .c1_d_source(c1_d_source),
    .c1_d_sink(c1_d_sink), .c1_d_denied(c1_d_denied), .c1_d_corrupt(c1_d_corrupt),
    .c1_d_data(c1_d_data),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model: who is next in turn, who owns a burst and how many beats remain.
  int m_next  = 0;
  int m_owner = -1;
  int m_rem   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      t_v[i] = 1'b0; t_op[i] = 3'd4; t_par[i] = '0; t_size[i] = 3'd2; t_src[i] = 1'b0;
      t_addr[i] = '0; t_mask[i] = '0; t_data[i] = '0; t_dready[i] = 1'b0;
    end
    t_mready = 1'b0; t_dvalid = 1'b0; t_dsrc = '0; t_dop = '0; t_dpar = '0; t_dsize = '0;
    t_dsink = 1'b0; t_ddenied = 1'b0; t_dcorrupt = 1'b0; t_ddata = '0;
  endtask

  task automatic set_a(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz);
    t_v[i] = v; t_op[i] = op; t_size[i] = sz;
    t_src[i] = 1'($urandom); t_addr[i] = 30'($urandom); t_data[i] = $urandom;
    t_mask[i] = 4'($urandom); t_par[i] = 3'($urandom);
  endtask

  function automatic int exp_grant();
    if (m_owner >= 0)        return m_owner;
    if (t_v[0] && t_v[1])    return m_next;
    if (t_v[1])              return 1;
    return 0;
  endfunction

  // One clock: check all combinational outputs against the model, then advance the model.
  task automatic cycle();
    int g, dst, bytes;
    logic fire;
    #1;
    g = exp_grant();
    chk("m_a_valid",   m_a_valid,   t_v[g]);
    chk("m_a_source",  m_a_source,  {g[0], t_src[g]});
    chk("m_a_address", m_a_address, t_addr[g]);
    chk("m_a_data",    {m_a_opcode, m_a_size, m_a_mask, m_a_data}, {t_op[g], t_size[g], t_mask[g], t_data[g]});
    chk("c0_a_ready",  c0_a_ready,  (g == 0) ? t_mready : 1'b0);
    chk("c1_a_ready",  c1_a_ready,  (g == 1) ? t_mready : 1'b0);
    chk("busy",        busy,        m_owner >= 0);
    dst = int'(t_dsrc[1]);
    chk("c0_d_valid",  c0_d_valid,  t_dvalid && dst == 0);
    chk("c1_d_valid",  c1_d_valid,  t_dvalid && dst == 1);
    chk("m_d_ready",   m_d_ready,   t_dready[dst]);
    chk("d_source",    (dst == 0) ? c0_d_source : c1_d_source, t_dsrc[0]);
    chk("d_bcast",     {c0_d_data, c1_d_data, c0_d_opcode, c1_d_param}, {t_ddata, t_ddata, t_dop, t_dpar});
    fire = t_v[g] && t_mready;
    @(posedge clock);
    if (fire) begin
      if (m_owner < 0) begin
        m_next = 1 - g;
        bytes  = 1 << t_size[g];
        if (t_op[g] <= 3'd3 && bytes > 4) begin
          m_owner = g;
          m_rem   = bytes / 4 - 1;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_owner = -1;
      end
    end
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_m_a_valid", m_a_valid, 1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_readys",    {c0_a_ready, c1_a_ready, c0_d_valid, c1_d_valid}, 4'b0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // Both clients issue Gets: grants alternate starting with client 0.
    t_mready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_a(0, 1'b1, 3'd4, 3'd2); set_a(1, 1'b1, 3'd4, 3'd2);
      t_src[0] = 1'b0; t_src[1] = 1'b0;
      #1;
      chk("alt_source", m_a_source, (k % 2 == 0) ? 2'b00 : 2'b10);
      cycle();
    end

    // c1 4-beat PutFull while c0 Get waits; make c1 the round-robin winner first.
    set_a(0, 1'b0, 3'd4, 3'd2); set_a(1, 1'b1, 3'd0, 3'd4);
    cycle();
    set_a(0, 1'b1, 3'd4, 3'd2); t_v[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("burst_busy", busy, 1'b1);
      cycle();
    end
    t_v[1] = 1'b0;
    #1; chk("after_burst_c0", c0_a_ready, 1'b1);
    cycle();

    // Mid-burst stall from c1: lock and blocking of c0 must persist.
    set_a(0, 1'b0, 3'd4, 3'd2); set_a(1, 1'b1, 3'd1, 3'd4);
    cycle();
    t_v[0] = 1'b1; t_v[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1; chk("stall_c0_ready", c0_a_ready, 1'b0);
      chk("stall_busy", busy, 1'b1);
      cycle();
    end
    t_v[1] = 1'b1;
    repeat (3) cycle();
    t_v[1] = 1'b0;
    cycle();

    // D routing to client 1 with back-pressure.
    t_dvalid = 1'b1; t_dsrc = 2'b11; t_dready[0] = 1'b1; t_dready[1] = 1'b0; t_ddata = $urandom;
    #1;
    chk("d_c1_valid", c1_d_valid, 1'b1);
    chk("d_c1_src",   c1_d_source, 1'b1);
    chk("d_c0_valid", c0_d_valid, 1'b0);
    chk("d_bp_ready", m_d_ready, 1'b0);
    cycle();
    t_dready[1] = 1'b1;
    #1; chk("d_ready_up", m_d_ready, 1'b1);
    cycle();
    t_dvalid = 1'b0;

    // Reset arrives after beat 2 of a c0 4-beat Put.
    set_a(1, 1'b0, 3'd4, 3'd2); set_a(0, 1'b1, 3'd0, 3'd4);
    repeat (2) cycle();
    reset = 1'b1;
    #2;
    chk("rst_async_busy", busy, 1'b0);
    m_next = 0; m_owner = -1; m_rem = 0;
    t_v[0] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    set_a(1, 1'b1, 3'd4, 3'd2);
    @(posedge clock); #1;
    #1; chk("post_rst_c1", c1_a_ready, 1'b1);
    cycle();

    // Manager back-pressure: grant must sit on the current pointer.
    t_mready = 1'b0;
    set_a(0, 1'b1, 3'd4, 3'd0); set_a(1, 1'b1, 3'd4, 3'd0);
    repeat (5) cycle();
    t_mready = 1'b1;
    #1; chk("bp_first_fire", m_a_source[1], 1'(m_next));
    cycle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 5));
        set_a(i, $urandom_range(0, 3) != 0, op, 3'($urandom_range(0, 4)));
        t_dready[i] = 1'($urandom);
      end
      t_mready = $urandom_range(0, 3) != 0;
      t_dvalid = 1'($urandom); t_dsrc = 2'($urandom); t_dop = 3'($urandom_range(0, 2));
      t_dpar = 2'($urandom); t_ddata = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
